// File: rtl/pixel_window_gen_pkg.sv
// Shared constants and helpers for the 3x3 pixel window generator.
package pixel_window_gen_pkg;

    // Each window element is a sample zero-extended to this many bits.
    localparam int unsigned WIN_ELEM_WIDTH = 9;
    // Window is WIN_SIZE x WIN_SIZE pixels.
    localparam int unsigned WIN_SIZE       = 3;
    localparam int unsigned WIN_ELEMS      = WIN_SIZE * WIN_SIZE;
    localparam int unsigned WIN_BUS_WIDTH  = WIN_ELEMS * WIN_ELEM_WIDTH;

    // Row roles inside the window: row 0 is the oldest line.
    localparam int unsigned WIN_ROW_OLDEST = 0;
    localparam int unsigned WIN_ROW_MIDDLE = 1;
    localparam int unsigned WIN_ROW_NEWEST = 2;
    // Column that receives the freshly accepted pixel column.
    localparam int unsigned WIN_COL_NEWEST = WIN_SIZE - 1;

    // Linear element index for (row, col).
    function automatic int unsigned win_elem_idx(input int unsigned row, input int unsigned col);
        return row * WIN_SIZE + col;
    endfunction

    // LSB position of element (row, col) on a window bus.
    function automatic int unsigned win_elem_lsb(input int unsigned row, input int unsigned col);
        return win_elem_idx(row, col) * WIN_ELEM_WIDTH;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line buffer: read-before-write with a registered read port.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 24,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Storage is never cleared; consumers gate out stale contents.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: only while enabled and write-enabled.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: captures the old contents at the addressed word, holds otherwise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_window_gen.sv
// Raster-order RGB stream to 3x3 sliding window generator (no border padding).
module pixel_window_gen
    import pixel_window_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_WIDTH-1:0]    in_r,
    input  logic [DATA_WIDTH-1:0]    in_g,
    input  logic [DATA_WIDTH-1:0]    in_b,
    output logic                     out_valid,
    output logic [WIN_BUS_WIDTH-1:0] out_r_win,
    output logic [WIN_BUS_WIDTH-1:0] out_g_win,
    output logic [WIN_BUS_WIDTH-1:0] out_b_win,
    output logic                     frame_done
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned PIX_W = 3 * DATA_WIDTH;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Raster position counters.
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;

    logic win_pos;
    logic out_valid_q, out_valid_d;
    logic frame_done_q, frame_done_d;

    // Packed pixel {r, g, b}.
    logic [PIX_W-1:0] pix_in;
    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] rd_a, rd_b;
    // Row parity of the last accepted pixel: selects which buffer holds the oldest line.
    logic             sel_q;

    // Window storage indexed [row][col]; the newest column is taken straight from the
    // line buffer read registers and the pixel register, so only the older columns live here.
    logic [WIN_SIZE-1:0][WIN_SIZE-2:0][PIX_W-1:0] shift_q;
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIX_W-1:0] live;
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIX_W-1:0] hold_q;
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIX_W-1:0] shown;

    assign pix_in = {in_r, in_g, in_b};

    // Effective position of the incoming pixel; start-of-frame forces the origin.
    always_comb begin
        pos_col = in_sof ? '0 : col_q;
        pos_row = in_sof ? '0 : row_q;
    end

    // Next-state for counters, window strobe and end-of-frame strobe.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_pos      = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            out_valid_d  = win_pos;
            frame_done_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
    end

    // Buffers alternate by row parity: the one written this row still holds row-2
    // at the current column (read-before-write), the other holds row-1.
    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buf_a (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (in_valid),
        .we_i    (in_valid && !pos_row[0]),
        .addr_i  (pos_col),
        .wdata_i (pix_in),
        .rdata_o (rd_a)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buf_b (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (in_valid),
        .we_i    (in_valid && pos_row[0]),
        .addr_i  (pos_col),
        .wdata_i (pix_in),
        .rdata_o (rd_b)
    );

    // Counters, strobes, newest pixel and buffer-role select.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_q        <= '0;
            sel_q        <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (in_valid) begin
                pix_q <= pix_in;
                sel_q <= pos_row[0];
            end
        end
    end

    // Assemble the current window: older columns from registers, newest from the buffers.
    always_comb begin
        live = '0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE - 1; c++) begin
                live[r][c] = shift_q[r][c];
            end
        end
        live[WIN_ROW_OLDEST][WIN_COL_NEWEST] = sel_q ? rd_b : rd_a;
        live[WIN_ROW_MIDDLE][WIN_COL_NEWEST] = sel_q ? rd_a : rd_b;
        live[WIN_ROW_NEWEST][WIN_COL_NEWEST] = pix_q;
    end

    // Shift the window left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE - 1; c++) begin
                    shift_q[r][c] <= live[r][c + 1];
                end
            end
        end
    end

    // Capture each emitted window so the ports stay frozen between emissions.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (out_valid_q) begin
            hold_q <= live;
        end
    end

    assign shown = out_valid_q ? live : hold_q;

    // Spread samples onto the window buses, zero-extended per element.
    always_comb begin
        out_r_win = '0;
        out_g_win = '0;
        out_b_win = '0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                out_r_win[win_elem_lsb(r, c) +: DATA_WIDTH] = shown[r][c][2*DATA_WIDTH +: DATA_WIDTH];
                out_g_win[win_elem_lsb(r, c) +: DATA_WIDTH] = shown[r][c][DATA_WIDTH +: DATA_WIDTH];
                out_b_win[win_elem_lsb(r, c) +: DATA_WIDTH] = shown[r][c][0 +: DATA_WIDTH];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Self-checking bench for pixel_window_gen on a 4x4 image.
module tb_pixel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_r, in_g, in_b;
    logic        out_valid;
    logic        frame_done;
    logic [80:0] out_r_win, out_g_win, out_b_win;

    always #5 clk = ~clk;

    pixel_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_r_win  (out_r_win),
        .out_g_win  (out_g_win),
        .out_b_win  (out_b_win),
        .frame_done (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    // Reference model: raster position, current frame image, expected outputs.
    int          m_row, m_col;
    logic [7:0]  img_r [H][W];
    logic [7:0]  img_g [H][W];
    logic [7:0]  img_b [H][W];
    logic        m_valid, m_fd;
    logic [80:0] m_wr, m_wg, m_wb;

    // Observed windows and frame_done pulses.
    logic [80:0] hist_r[$];
    logic [80:0] hist_g[$];
    int          fd_total = 0;

    task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [80:0] win9(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
        int v[9];
        logic [80:0] w;
        v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*9 +: 9] = {1'b0, v[k][7:0]};
        return w;
    endfunction

    task automatic model_step();
        if (reset) begin
            armed   = 1'b1;
            m_row   = 0;
            m_col   = 0;
            m_valid = 1'b0;
            m_fd    = 1'b0;
            m_wr    = '0;
            m_wg    = '0;
            m_wb    = '0;
        end else begin
            m_valid = 1'b0;
            m_fd    = 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    m_row = 0;
                    m_col = 0;
                end
                img_r[m_row][m_col] = in_r;
                img_g[m_row][m_col] = in_g;
                img_b[m_row][m_col] = in_b;
                if (m_row >= 2 && m_col >= 2) begin
                    m_valid = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            m_wr[(i*3+j)*9 +: 9] = {1'b0, img_r[m_row-2+i][m_col-2+j]};
                            m_wg[(i*3+j)*9 +: 9] = {1'b0, img_g[m_row-2+i][m_col-2+j]};
                            m_wb[(i*3+j)*9 +: 9] = {1'b0, img_b[m_row-2+i][m_col-2+j]};
                        end
                    end
                end
                m_fd = (m_row == H-1) && (m_col == W-1);
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = (m_row + 1) % H;
                end
            end
        end
    endtask

    // One clock: model consumes the inputs at the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (armed) begin
            check("out_valid", {80'b0, out_valid}, {80'b0, m_valid});
            check("frame_done", {80'b0, frame_done}, {80'b0, m_fd});
            check("out_r_win", out_r_win, m_wr);
            check("out_g_win", out_g_win, m_wg);
            check("out_b_win", out_b_win, m_wb);
            if (out_valid === 1'b1) begin
                hist_r.push_back(out_r_win);
                hist_g.push_back(out_g_win);
            end
            if (frame_done === 1'b1) fd_total++;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pix(input int r, input int g, input int b, input bit sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_r     = r[7:0];
        in_g     = g[7:0];
        in_b     = b[7:0];
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input bit sof, input bit gaps);
        for (int p = 0; p < W*H; p++) begin
            pix(p, p + 100, p + 200, sof && (p == 0));
            if (gaps) idle(1);
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) tick();
        reset    = 1'b0;
    endtask

    logic [80:0] lit_first_r, lit_first_g, lit_last_r;
    int base, fbase;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_r     = '0;
        in_g     = '0;
        in_b     = '0;
        lit_first_r = win9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        lit_first_g = win9(100, 101, 102, 104, 105, 106, 108, 109, 110);
        lit_last_r  = win9(5, 6, 7, 9, 10, 11, 13, 14, 15);

        do_reset(3);
        check("reset_out_valid", {80'b0, out_valid}, 81'd0);
        check("reset_r_win", out_r_win, 81'd0);
        idle(2);

        // Continuous frame with sof on pixel 0.
        base  = hist_r.size();
        fbase = fd_total;
        for (int p = 0; p < W*H; p++) begin
            pix(p, p + 100, p + 200, p == 0);
            if (p == 9)  check("s1_no_window_after_px9", {80'b0, out_valid}, 81'd0);
            if (p == 10) begin
                check("s1_window_after_px10", {80'b0, out_valid}, 81'd1);
                check("s1_first_r_lit", out_r_win, lit_first_r);
                check("s1_first_g_lit", out_g_win, lit_first_g);
            end
            if (p == 15) begin
                check("s1_last_r_lit", out_r_win, lit_last_r);
                check("s1_frame_done_lit", {80'b0, frame_done}, 81'd1);
            end
        end
        idle(2);
        check("s1_count", hist_r.size() - base, 81'd4);
        check("s1_fd_count", fd_total - fbase, 81'd1);

        // Same frame with gaps.
        base  = hist_r.size();
        fbase = fd_total;
        frame(1'b1, 1'b1);
        idle(2);
        check("s2_count", hist_r.size() - base, 81'd4);
        check("s2_first_r", (hist_r.size() > base) ? hist_r[base] : 81'bx, lit_first_r);
        check("s2_last_r", (hist_r.size() > base + 3) ? hist_r[base+3] : 81'bx, lit_last_r);
        check("s2_fd_count", fd_total - fbase, 81'd1);

        // Partial frame then sof restart.
        base = hist_r.size();
        for (int p = 0; p < 6; p++) pix(p + 50, p + 150, p + 250, p == 0);
        frame(1'b1, 1'b0);
        idle(1);
        check("s3_count", hist_r.size() - base, 81'd4);
        check("s3_first_r", (hist_r.size() > base) ? hist_r[base] : 81'bx, lit_first_r);
        check("s3_first_g", (hist_g.size() > base) ? hist_g[base] : 81'bx, lit_first_g);

        // Reset after pixel 9, then a frame without sof.
        for (int p = 0; p < 10; p++) pix(p + 30, p + 130, p + 230, p == 0);
        do_reset(2);
        check("s4_reset_r_win", out_r_win, 81'd0);
        check("s4_reset_valid", {80'b0, out_valid}, 81'd0);
        base  = hist_r.size();
        fbase = fd_total;
        frame(1'b0, 1'b0);
        idle(1);
        check("s4_count", hist_r.size() - base, 81'd4);
        check("s4_first_r", (hist_r.size() > base) ? hist_r[base] : 81'bx, lit_first_r);
        check("s4_last_r", (hist_r.size() > base + 3) ? hist_r[base+3] : 81'bx, lit_last_r);
        check("s4_fd_count", fd_total - fbase, 81'd1);

        // Two back-to-back frames.
        base  = hist_r.size();
        fbase = fd_total;
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        idle(1);
        check("s5_count", hist_r.size() - base, 81'd8);
        check("s5_fd_count", fd_total - fbase, 81'd2);
        check("s5_second_first_r", (hist_r.size() > base + 4) ? hist_r[base+4] : 81'bx,
              lit_first_r);

        // Randomised traffic: gaps, random data, occasional sof and reset.
        for (int it = 0; it < 800; it++) begin
            int k;
            k = $urandom_range(0, 99);
            if (k < 1) begin
                do_reset(1 + $urandom_range(0, 2));
            end else if (k < 25) begin
                idle(1 + $urandom_range(0, 2));
            end else begin
                pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 39) == 0);
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
